hazard_controller: RTL and testbench

Pipeline hazard sequencer for the 5-stage MIPS datapath. It detects load-use hazards, taken branches resolved in MEM, and data-memory wait states. It drives the control-selection input of the ID-stage bubble mux (1 = pass decoded controls, 0 = insert bubble), the PC and IF/ID write enables, and the stage flush and freeze signals. It holds a small FSM, a memory-wait timeout, and saturating event counters for debug.

---
 rtl/hazard_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch / memory-wait hazard sequencer for the 5-stage pipeline
module hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memaccess_i,
    input  logic             dmem_ready_i,
    output logic             ctrl_sel_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pipe_en_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]    WAIT_LIMIT = WW'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_WAIT  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wcnt_q, wcnt_d, wcnt_next;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              timeout_q, timeout_d;

    logic lu, mw, br;

    // Hazard terms; register $0 never creates a dependency.
    assign lu = idex_memread_i & (idex_rt_i != 5'd0) &
                ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    assign mw = exmem_memaccess_i & ~dmem_ready_i;
    assign br = branch_taken_i;

    // Wait count the FSM would hold after another frozen cycle.
    assign wcnt_next = (state_q == S_WAIT) ? (wcnt_q + WW'(1)) : WW'(1);

    // State, wait counter, event counters and the sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic and Mealy decode of the pipeline controls; mw > br > lu.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = '0;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        timeout_d     = timeout_q;
        ctrl_sel_o    = 1'b1;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        pipe_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;

        if (state_q == S_ERR) begin
            state_d      = S_ERR;
            ctrl_sel_o   = 1'b0;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_en_o    = 1'b0;
        end else if (mw) begin
            // Freeze everything; EX/MEM keeps any pending branch for later.
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_en_o    = 1'b0;
            if (wcnt_next == WAIT_LIMIT) begin
                state_d   = S_ERR;
                timeout_d = 1'b1;
            end else begin
                state_d = S_WAIT;
                wcnt_d  = wcnt_next;
            end
        end else if (br) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            ctrl_sel_o    = 1'b0;
            state_d       = S_RUN;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (lu && (state_q != S_STALL)) begin
            // One bubble into ID/EX while PC and IF/ID hold.
            ctrl_sel_o   = 1'b0;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            state_d      = S_STALL;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            state_d = S_RUN;
        end

        // Held in reset: keep the pipeline frozen and inert.
        if (!rst_i) begin
            ctrl_sel_o    = 1'b0;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_en_o     = 1'b0;
            ifid_flush_o  = 1'b0;
            idex_flush_o  = 1'b0;
            exmem_flush_o = 1'b0;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rstn, t_mr, t_br, t_ma, t_rdy;
    logic [4:0] t_idex_rt, t_rs, t_rt;

    logic        ctrl_sel, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_ctrl_sel, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_en, s_mem_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    hazard_controller #(.MAX_WAIT(16), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(t_rstn), .idex_memread_i(t_mr), .idex_rt_i(t_idex_rt),
        .ifid_rs_i(t_rs), .ifid_rt_i(t_rt), .branch_taken_i(t_br),
        .exmem_memaccess_i(t_ma), .dmem_ready_i(t_rdy),
        .ctrl_sel_o(ctrl_sel), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush),
        .pipe_en_o(pipe_en), .mem_timeout_o(mem_timeout),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_controller #(.MAX_WAIT(16), .CNT_W(2)) u_dut_sat (
        .clk_i(clk), .rst_i(t_rstn), .idex_memread_i(t_mr), .idex_rt_i(t_idex_rt),
        .ifid_rs_i(t_rs), .ifid_rt_i(t_rt), .branch_taken_i(t_br),
        .exmem_memaccess_i(t_ma), .dmem_ready_i(t_rdy),
        .ctrl_sel_o(s_ctrl_sel), .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
        .ifid_flush_o(s_ifid_flush), .idex_flush_o(s_idex_flush), .exmem_flush_o(s_exmem_flush),
        .pipe_en_o(s_pipe_en), .mem_timeout_o(s_mem_timeout),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    typedef struct packed {
        logic        ctrl, pcw, ifw, pen;
        logic [2:0]  fl;
        logic        to;
        logic [15:0] sc, fc;
        logic [1:0]  ssc, sfc;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: 0 RUN, 1 STALL, 2 WAIT, 3 ERR.
    int m_st = 0, m_w = 0, m_sc = 0, m_fc = 0, m_ssc = 0, m_sfc = 0;
    bit m_to = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic rstn, input logic mr, input logic [4:0] irt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic br,
                         input logic ma, input logic rdy);
        exp_t e;
        bit lu, mw;
        int nw;
        @(negedge clk);
        t_rstn = rstn; t_mr = mr; t_idex_rt = irt; t_rs = rs; t_rt = rt;
        t_br = br; t_ma = ma; t_rdy = rdy;
        lu = mr && (irt != 0) && ((irt == rs) || (irt == rt));
        mw = ma && !rdy;
        e.ctrl = 1; e.pcw = 1; e.ifw = 1; e.pen = 1; e.fl = 3'b000;
        if (!rstn || m_st == 3) begin
            e.ctrl = 0; e.pcw = 0; e.ifw = 0; e.pen = 0;
        end else if (mw) begin
            e.pcw = 0; e.ifw = 0; e.pen = 0;
        end else if (br) begin
            e.fl = 3'b111; e.ctrl = 0;
        end else if (lu && m_st != 1) begin
            e.ctrl = 0; e.pcw = 0; e.ifw = 0;
        end
        e.to = m_to; e.sc = 16'(m_sc); e.fc = 16'(m_fc); e.ssc = 2'(m_ssc); e.sfc = 2'(m_sfc);
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk("ctrl_sel",    16'(ctrl_sel),    16'(e.ctrl));
        chk("pc_write",    16'(pc_write),    16'(e.pcw));
        chk("ifid_write",  16'(ifid_write),  16'(e.ifw));
        chk("pipe_en",     16'(pipe_en),     16'(e.pen));
        chk("flushes",     16'({ifid_flush, idex_flush, exmem_flush}), 16'(e.fl));
        chk("mem_timeout", 16'(mem_timeout), 16'(e.to));
        chk("stall_cnt",   stall_cnt,        e.sc);
        chk("flush_cnt",   flush_cnt,        e.fc);
        chk("sat_ctrls",   16'({s_ctrl_sel, s_pc_write, s_ifid_write, s_pipe_en, s_ifid_flush, s_idex_flush, s_exmem_flush}),
                           16'({e.ctrl, e.pcw, e.ifw, e.pen, e.fl}));
        chk("sat_timeout", 16'(s_mem_timeout), 16'(e.to));
        chk("sat_stall_cnt", 16'(s_stall_cnt), 16'(e.ssc));
        chk("sat_flush_cnt", 16'(s_flush_cnt), 16'(e.sfc));
        // Advance the model across the coming rising edge.
        if (!rstn) begin
            m_st = 0; m_w = 0; m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0; m_to = 0;
        end else if (m_st == 3) begin
            m_st = 3;
        end else if (mw) begin
            nw = (m_st == 2) ? m_w + 1 : 1;
            if (nw >= 16) begin m_st = 3; m_to = 1; m_w = 0; end
            else begin m_st = 2; m_w = nw; end
        end else if (br) begin
            m_st = 0; m_w = 0;
            if (m_fc < 65535) m_fc++;
            if (m_sfc < 3) m_sfc++;
        end else if (lu && m_st != 1) begin
            m_st = 1; m_w = 0;
            if (m_sc < 65535) m_sc++;
            if (m_ssc < 3) m_ssc++;
        end else begin
            m_st = 0; m_w = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        t_rstn = 0; t_mr = 0; t_idex_rt = 0; t_rs = 0; t_rt = 0; t_br = 0; t_ma = 0; t_rdy = 1;
        do_reset(2);
        idle(1);
        // Load-use on Rs: one bubble, then STALL ignores the still-matching fields.
        cycle(1, 1, 8, 8, 3, 0, 0, 1);
        cycle(1, 1, 8, 8, 3, 0, 0, 1);
        idle(1);
        // Load-use on Rt.
        cycle(1, 1, 9, 2, 9, 0, 0, 1);
        idle(1);
        // Register $0 never stalls.
        cycle(1, 1, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 5, 0, 0, 0, 1);
        // Branch while load-use: flush wins, no bubble.
        cycle(1, 1, 8, 8, 0, 1, 0, 1);
        idle(1);
        // Memory wait 5 cycles, then ready.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // Freeze beats branch; branch acted on when mw drops.
        cycle(1, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 1, 1, 1);
        // Load-use evaluated from WAIT.
        cycle(1, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 1, 7, 7, 0, 0, 0, 1);
        idle(1);
        // Drive the 2-bit flush counter past saturation.
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        // Reset mid-STALL and mid-WAIT.
        cycle(1, 1, 4, 4, 0, 0, 0, 1);
        do_reset(1);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 0);
        do_reset(1);
        idle(1);
        // Wait just short of the limit recovers.
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // Timeout after 16 frozen cycles; ERR holds regardless of inputs.
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 8, 8, 0, 1, 0, 1);
        idle(2);
        do_reset(1);
        idle(1);
        cycle(1, 1, 8, 8, 0, 0, 0, 1);
        idle(1);
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
